// File: rtl/mips_exec_pc_core.sv
`default_nettype none
// =============================================================================
// mips_exec_pc_core : PC register, PC+4 / branch target, main ALU, branch
//                     condition and proposed HI/LO values.   Revision: 1.0
// =============================================================================
module mips_exec_pc_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_address,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt_instr,
    input  logic [4:0]  shamt,
    input  logic [5:0]  functcode,
    input  logic [15:0] immediate,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic [31:0] alu_result,
    output logic        sig_branch,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_REGIMM  = 6'h01;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_BLEZ    = 6'h06;
    localparam logic [5:0] c_OP_BGTZ    = 6'h07;
    localparam logic [5:0] c_OP_ADDI    = 6'h08;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_SLTI    = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU   = 6'h0B;
    localparam logic [5:0] c_OP_ANDI    = 6'h0C;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_XORI    = 6'h0E;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_SLLV  = 6'h04;
    localparam logic [5:0] c_FN_SRLV  = 6'h06;
    localparam logic [5:0] c_FN_SRAV  = 6'h07;
    localparam logic [5:0] c_FN_MTHI  = 6'h11;
    localparam logic [5:0] c_FN_MTLO  = 6'h13;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    logic [31:0] r_pc;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic signed [31:0] w_rs_s;
    logic signed [31:0] w_div_s;
    logic [31:0] w_div_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_VECTOR;
        end else if (clk_enable) begin
            r_pc <= pc_in;
        end
    end

    assign pc_out         = r_pc;
    assign pc_plus4       = r_pc + 32'd4;
    assign w_simm         = {{16{immediate[15]}}, immediate};
    assign w_zimm         = {16'h0000, immediate};
    assign branch_address = pc_plus4 + {w_simm[29:0], 2'b00};

    // Lower 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_s = {{32{rs_content[31]}}, rs_content} * {{32{rt_content[31]}}, rt_content};
    assign w_prod_u = {32'h0, rs_content} * {32'h0, rt_content};

    // Dividing by 1 in the zero and 0x80000000/-1 cases keeps the divider defined;
    // for the overflow case it also yields exactly quotient 0x80000000, remainder 0.
    assign w_div_zero = (rt_content == 32'h0);
    assign w_div_ovf  = (rs_content == 32'h80000000) && (rt_content == 32'hFFFFFFFF);
    assign w_rs_s     = rs_content;
    assign w_div_s    = (w_div_zero || w_div_ovf) ? 32'sd1 : rt_content;
    assign w_div_u    = w_div_zero ? 32'd1 : rt_content;
    assign w_quot_s   = w_rs_s / w_div_s;
    assign w_rem_s    = w_rs_s % w_div_s;
    assign w_quot_u   = rs_content / w_div_u;
    assign w_rem_u    = rs_content % w_div_u;

    always_comb begin
        alu_result = 32'h0;
        sig_branch = 1'b0;
        hi         = 32'h0;
        lo         = 32'h0;
        case (opcode)
            c_OP_SPECIAL: begin
                case (functcode)
                    c_FN_SLL:   alu_result = rt_content << shamt;
                    c_FN_SRL:   alu_result = rt_content >> shamt;
                    c_FN_SRA:   alu_result = $signed(rt_content) >>> shamt;
                    c_FN_SLLV:  alu_result = rt_content << rs_content[4:0];
                    c_FN_SRLV:  alu_result = rt_content >> rs_content[4:0];
                    c_FN_SRAV:  alu_result = $signed(rt_content) >>> rs_content[4:0];
                    c_FN_ADD, c_FN_ADDU: alu_result = rs_content + rt_content;
                    c_FN_SUB, c_FN_SUBU: alu_result = rs_content - rt_content;
                    c_FN_AND:   alu_result = rs_content & rt_content;
                    c_FN_OR:    alu_result = rs_content | rt_content;
                    c_FN_XOR:   alu_result = rs_content ^ rt_content;
                    c_FN_NOR:   alu_result = ~(rs_content | rt_content);
                    c_FN_SLT:   alu_result = {31'h0, $signed(rs_content) < $signed(rt_content)};
                    c_FN_SLTU:  alu_result = {31'h0, rs_content < rt_content};
                    c_FN_MULT:  {hi, lo} = w_prod_s;
                    c_FN_MULTU: {hi, lo} = w_prod_u;
                    c_FN_DIV: begin
                        hi = w_div_zero ? rs_content : w_rem_s;
                        lo = w_div_zero ? 32'h0 : w_quot_s;
                    end
                    c_FN_DIVU: begin
                        hi = w_div_zero ? rs_content : w_rem_u;
                        lo = w_div_zero ? 32'h0 : w_quot_u;
                    end
                    c_FN_MTHI:  hi = rs_content;
                    c_FN_MTLO:  lo = rs_content;
                    default:    ;
                endcase
            end
            c_OP_REGIMM: begin
                case (rt_instr)
                    5'h00, 5'h10: sig_branch = rs_content[31];
                    5'h01, 5'h11: sig_branch = ~rs_content[31];
                    default:      ;
                endcase
            end
            c_OP_BEQ:   sig_branch = (rs_content == rt_content);
            c_OP_BNE:   sig_branch = (rs_content != rt_content);
            c_OP_BLEZ:  sig_branch = rs_content[31] || (rs_content == 32'h0);
            c_OP_BGTZ:  sig_branch = !rs_content[31] && (rs_content != 32'h0);
            c_OP_ADDI, c_OP_ADDIU: alu_result = rs_content + w_simm;
            c_OP_SLTI:  alu_result = {31'h0, $signed(rs_content) < $signed(w_simm)};
            c_OP_SLTIU: alu_result = {31'h0, rs_content < w_simm};
            c_OP_ANDI:  alu_result = rs_content & w_zimm;
            c_OP_ORI:   alu_result = rs_content | w_zimm;
            c_OP_XORI:  alu_result = rs_content ^ w_zimm;
            c_OP_LUI:   alu_result = {immediate, 16'h0000};
            // Loads and stores: byte address rs+simm, no alignment masking.
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: alu_result = rs_content + w_simm;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_pc_core.sv
`default_nettype none
// Bench for mips_exec_pc_core: arithmetic reference model checked every negedge,
// plus hand-computed literal expectations.
module tb_mips_exec_pc_core;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] pc_out, pc_plus4, branch_address;
    logic [5:0]  opcode = 6'h0;
    logic [4:0]  rt_instr = 5'h0;
    logic [4:0]  shamt = 5'h0;
    logic [5:0]  functcode = 6'h0;
    logic [15:0] immediate = 16'h0;
    logic [31:0] rs_content = 32'h0;
    logic [31:0] rt_content = 32'h0;
    logic [31:0] alu_result, hi, lo;
    logic        sig_branch;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;
    logic [31:0] m_pc;

    mips_exec_pc_core #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .pc_in(pc_in),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .branch_address(branch_address),
        .opcode(opcode), .rt_instr(rt_instr), .shamt(shamt), .functcode(functcode),
        .immediate(immediate), .rs_content(rs_content), .rt_content(rt_content),
        .alu_result(alu_result), .sig_branch(sig_branch), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules evaluated with 64-bit integer arithmetic.
    function automatic void model(input logic [5:0] op, input logic [4:0] rti,
                                  input logic [4:0] sh, input logic [5:0] fn,
                                  input logic [15:0] imm, input logic [31:0] rs,
                                  input logic [31:0] rt, output logic [31:0] alu,
                                  output logic br, output logic [31:0] mhi,
                                  output logic [31:0] mlo);
        longint srs, srt, simm, p;
        longint unsigned urs, urt, uimm, up;
        int vs;
        srs = longint'($signed(rs));
        srt = longint'($signed(rt));
        simm = longint'($signed(imm));
        urs = {32'h0, rs};
        urt = {32'h0, rt};
        uimm = {48'h0, imm};
        vs = int'(rs[4:0]);
        alu = 0; br = 0; mhi = 0; mlo = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h00: alu = 32'(urt << sh);
                6'h02: alu = 32'(urt >> sh);
                6'h03: alu = 32'(srt >>> sh);
                6'h04: alu = 32'(urt << vs);
                6'h06: alu = 32'(urt >> vs);
                6'h07: alu = 32'(srt >>> vs);
                6'h20, 6'h21: alu = 32'(srs + srt);
                6'h22, 6'h23: alu = 32'(srs - srt);
                6'h24: alu = rs & rt;
                6'h25: alu = rs | rt;
                6'h26: alu = rs ^ rt;
                6'h27: alu = ~(rs | rt);
                6'h2A: alu = (srs < srt) ? 1 : 0;
                6'h2B: alu = (urs < urt) ? 1 : 0;
                6'h18: begin p = srs * srt; {mhi, mlo} = p; end
                6'h19: begin up = urs * urt; {mhi, mlo} = up; end
                6'h1A: if (rt == 0) mhi = rs;
                       else begin mlo = 32'(srs / srt); mhi = 32'(srs % srt); end
                6'h1B: if (rt == 0) mhi = rs;
                       else begin mlo = 32'(urs / urt); mhi = 32'(urs % urt); end
                6'h11: mhi = rs;
                6'h13: mlo = rs;
                default: ;
            endcase
        end else begin
            case (op)
                6'h01: br = ((rti == 0 || rti == 16) && srs < 0) ||
                            ((rti == 1 || rti == 17) && srs >= 0);
                6'h04: br = (rs == rt);
                6'h05: br = (rs != rt);
                6'h06: br = (srs <= 0);
                6'h07: br = (srs > 0);
                6'h08, 6'h09: alu = 32'(srs + simm);
                6'h0A: alu = (srs < simm) ? 1 : 0;
                6'h0B: alu = (urs < 64'(32'(simm))) ? 1 : 0;
                6'h0C: alu = 32'(urs & uimm);
                6'h0D: alu = 32'(urs | uimm);
                6'h0E: alu = 32'(urs ^ uimm);
                6'h0F: alu = 32'(uimm * 65536);
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: alu = 32'(srs + simm);
                default: ;
            endcase
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_pc <= RV;
        else if (clk_enable) m_pc <= pc_in;
    end

    always @(negedge clk) begin
        logic [31:0] e_alu, e_hi, e_lo;
        logic e_br;
        if (chk_en) begin
            model(opcode, rt_instr, shamt, functcode, immediate, rs_content, rt_content,
                  e_alu, e_br, e_hi, e_lo);
            check("m_pc_out", pc_out, m_pc);
            check("m_pc_plus4", pc_plus4, 32'(longint'(m_pc) + 4));
            check("m_branch_address", branch_address,
                  32'(longint'(m_pc) + 4 + longint'($signed(immediate)) * 4));
            check("m_alu_result", alu_result, e_alu);
            check("m_sig_branch", {31'h0, sig_branch}, {31'h0, e_br});
            check("m_hi", hi, e_hi);
            check("m_lo", lo, e_lo);
        end
    end

    task automatic vec(input logic [5:0] op, input logic [4:0] rti, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk);
        #1;
        opcode = op; rt_instr = rti; shamt = sh; functcode = fn;
        immediate = imm; rs_content = rs; rt_content = rt;
        #1;
    endtask

    logic [5:0] fn_list [0:27] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                   6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                   6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h01, 6'h3F};
    logic [31:0] rs_list [0:3] = '{32'h80000005, 32'h12345678, 32'hFFFFFFF9, 32'h00000000};
    logic [31:0] rt_list [0:3] = '{32'h7FFFFFF3, 32'hFFFFFFF0, 32'h00000002, 32'h80000000};

    initial begin
        #3 reset = 1'b1;
        #1;
        check("reset_pc_out", pc_out, 32'hBFC00000);
        check("reset_pc_plus4", pc_plus4, 32'hBFC00004);
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        immediate = 16'hFFFF;
        #1 check("br_addr_minus1", branch_address, 32'hBFC00000);
        immediate = 16'h0003;
        #1 check("br_addr_plus3", branch_address, 32'hBFC00010);
        pc_in = 32'hBFC00010;
        clk_enable = 1'b1;
        @(posedge clk);
        #1 clk_enable = 1'b0;
        check("pc_load", pc_out, 32'hBFC00010);
        @(posedge clk);
        #1 check("pc_hold", pc_out, 32'hBFC00010);
        pc_in = 32'hFFFFFFFC;
        clk_enable = 1'b1;
        @(posedge clk);
        #1 clk_enable = 1'b0;
        check("pc_plus4_wrap", pc_plus4, 32'h00000000);

        vec(6'h09, 0, 0, 0, 16'hFFFF, 32'd5, 0);          check("addiu", alu_result, 32'd4);
        vec(6'h0B, 0, 0, 0, 16'hFFFF, 32'd1, 0);          check("sltiu", alu_result, 32'd1);
        vec(6'h0A, 0, 0, 0, 16'hFFFF, 32'd1, 0);          check("slti", alu_result, 32'd0);
        vec(6'h0D, 0, 0, 0, 16'h1234, 32'hFFFF0000, 0);   check("ori", alu_result, 32'hFFFF1234);
        vec(6'h0F, 0, 0, 0, 16'h8000, 0, 0);              check("lui", alu_result, 32'h80000000);
        vec(6'h00, 0, 4, 6'h03, 0, 0, 32'h80000000);      check("sra", alu_result, 32'hF8000000);
        vec(6'h23, 0, 0, 0, 16'hFFFC, 32'h1000, 0);       check("lw_addr", alu_result, 32'h00000FFC);
        vec(6'h04, 0, 0, 0, 0, 32'd7, 32'd7);             check("beq", {31'h0, sig_branch}, 32'd1);
        vec(6'h05, 0, 0, 0, 0, 32'd7, 32'd7);             check("bne", {31'h0, sig_branch}, 32'd0);
        vec(6'h06, 0, 0, 0, 0, 32'd0, 0);                 check("blez", {31'h0, sig_branch}, 32'd1);
        vec(6'h07, 0, 0, 0, 0, 32'd0, 0);                 check("bgtz", {31'h0, sig_branch}, 32'd0);
        vec(6'h01, 5'h11, 0, 0, 0, 32'h80000000, 0);      check("bgezal", {31'h0, sig_branch}, 32'd0);
        vec(6'h01, 5'h00, 0, 0, 0, 32'h80000000, 0);      check("bltz", {31'h0, sig_branch}, 32'd1);
        vec(6'h00, 0, 0, 6'h21, 0, 32'd7, 32'd7);         check("addu_br", {31'h0, sig_branch}, 32'd0);
        check("addu", alu_result, 32'd14);
        vec(6'h00, 0, 0, 6'h18, 0, 32'hFFFFFFFE, 32'd3);  check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        vec(6'h00, 0, 0, 6'h19, 0, 32'hFFFFFFFF, 32'd2);  check("multu_hi", hi, 32'd1);
        check("multu_lo", lo, 32'hFFFFFFFE);
        vec(6'h00, 0, 0, 6'h1A, 0, 32'hFFFFFFF9, 32'd2);  check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        vec(6'h00, 0, 0, 6'h1B, 0, 32'd7, 32'd0);         check("divu0_hi", hi, 32'd7);
        check("divu0_lo", lo, 32'd0);
        vec(6'h00, 0, 0, 6'h1A, 0, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'd0);
        vec(6'h00, 0, 0, 6'h3F, 16'h1234, 32'h55, 32'h66);
        check("unk_alu", alu_result, 32'd0);
        check("unk_hilo", hi | lo, 32'd0);

        // Broad directed sweep, checked by the model on every negedge.
        foreach (fn_list[f])
            for (int k = 0; k < 4; k++)
                vec(6'h00, 0, 5'd7, fn_list[f], 16'h0, rs_list[k], rt_list[k]);
        for (int op = 1; op < 64; op++)
            for (int k = 0; k < 2; k++)
                vec(6'(op), (k == 0) ? 5'h10 : 5'h01, 0, 6'h0, (k == 0) ? 16'h8001 : 16'h7FFE,
                    rs_list[k + 1], rt_list[k + 1]);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
